// File: rtl/sram_wait_model_if.sv
// -----------------------------------------------------------------------------
// sram_wait_model_if
// Purpose : control/status bundle between a memory master (CPU memory FSM or
//           bench) and the sram_wait_model test memory. The bidirectional
//           data bus I_O is a resolved net and stays a plain inout port on the
//           memory so the tristate is kept at module level.
// Signals : CE, OE, WE      active-low chip/output/write enables
//           BE              active-low byte-lane enables (BE[0] = bits 7:0)
//           A               word address
//           Ready           read data valid / write accepted
//           Err             1-cycle pulse on an out-of-range access
//           rd_count        completed reads (wraps)
//           wr_count        completed writes (wraps)
// Modports: master drives CE/OE/WE/BE/A; slave drives the status outputs.
// -----------------------------------------------------------------------------
interface sram_wait_model_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned CNT_W  = 16
);
    logic                  CE;
    logic                  OE;
    logic                  WE;
    logic [DATA_W/8-1:0]   BE;
    logic [ADDR_W-1:0]     A;
    logic                  Ready;
    logic                  Err;
    logic [CNT_W-1:0]      rd_count;
    logic [CNT_W-1:0]      wr_count;

    modport master (
        output CE, OE, WE, BE, A,
        input  Ready, Err, rd_count, wr_count
    );

    modport slave (
        input  CE, OE, WE, BE, A,
        output Ready, Err, rd_count, wr_count
    );
endinterface

// File: rtl/sram_wait_model.sv
// -----------------------------------------------------------------------------
// sram_wait_model
// Purpose : cycle-accurate SRAM model with configurable width, depth and read
//           wait states, used as the test memory behind the SLC-3 CPU.
// Ports   : Clk    rising-edge clock
//           Reset  synchronous, active-high (memory contents are preserved)
//           bus    sram_wait_model_if.slave: CE/OE/WE/BE/A in,
//                  Ready/Err/rd_count/wr_count out
//           I_O    bidirectional data bus, driven only while in RD_DRIVE
// Timing  : a read sampled at edge k drives data from edge k+READ_LAT+1.
//           A write commits on the edge it is sampled.
// -----------------------------------------------------------------------------
module sram_wait_model #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    sram_wait_model_if.slave    bus,
    inout  wire  [DATA_W-1:0]   I_O
);
    localparam int unsigned LANES = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_HOLD
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   lat_a;
    logic [LANES-1:0]    lat_be;
    logic                lat_oor;
    logic [3:0]          wait_cnt;
    logic [DATA_W-1:0]   dout;
    logic                drive;
    logic                ready;
    logic                err;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    wr_cnt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    lat_idx;
    logic                wr_req;
    logic                rd_req;
    logic                wr_fire;
    logic [DATA_W-1:0]   rd_word;

    assign in_range = ({1'b0, bus.A} < DEPTH_EXT);
    assign idx      = bus.A[IDX_W-1:0];
    assign lat_idx  = lat_a[IDX_W-1:0];

    // WE wins over OE so a simultaneous WE/OE request never turns the bus around.
    assign wr_req  = !bus.CE && !bus.WE;
    assign rd_req  = !bus.CE && bus.WE && !bus.OE;
    assign wr_fire = !Reset && (state == IDLE) && wr_req && in_range;

    // Read word with disabled lanes forced to zero; out-of-range reads return 0.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!lat_be[i]) begin
                rd_word[8*i +: 8] = mem[lat_idx][8*i +: 8];
            end
        end
        if (lat_oor) begin
            rd_word = '0;
        end
    end

    // Storage has no reset so contents survive Reset.
    always_ff @(posedge Clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (!bus.BE[i]) begin
                    mem[idx][8*i +: 8] <= I_O[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            lat_a    <= '0;
            lat_be   <= '1;
            lat_oor  <= 1'b0;
            wait_cnt <= '0;
            dout     <= '0;
            drive    <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state <= WR_HOLD;
                        ready <= 1'b1;
                        if (in_range) begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (rd_req) begin
                        state    <= RD_WAIT;
                        lat_a    <= bus.A;
                        lat_be   <= bus.BE;
                        lat_oor  <= !in_range;
                        wait_cnt <= 4'(READ_LAT);
                        err      <= !in_range;
                    end
                end

                // Counter reaching 0 costs one more edge, which gives the
                // k+READ_LAT+1 data timing for every READ_LAT including 0.
                RD_WAIT: begin
                    if (bus.CE || bus.OE || (bus.A != lat_a)) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state  <= RD_DRIVE;
                        dout   <= rd_word;
                        drive  <= 1'b1;
                        ready  <= 1'b1;
                        rd_cnt <= rd_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                RD_DRIVE: begin
                    if (bus.CE || bus.OE || !bus.WE || (bus.A != lat_a)) begin
                        state <= IDLE;
                        drive <= 1'b0;
                        ready <= 1'b0;
                    end
                end

                WR_HOLD: begin
                    if (bus.WE || bus.CE) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    drive <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign I_O          = drive ? dout : 'z;
    assign bus.Ready    = ready;
    assign bus.Err      = err;
    assign bus.rd_count = rd_cnt;
    assign bus.wr_count = wr_cnt;
endmodule

// File: tb/tb_sram_wait_model.sv
// -----------------------------------------------------------------------------
// tb_sram_wait_model
// Purpose : self-checking bench for sram_wait_model. Instance A uses the
//           default geometry (16-bit, READ_LAT=2); instance B uses DATA_W=32,
//           READ_LAT=0, CNT_W=4 to exercise zero-latency reads and counter wrap.
//           Expected read data comes from a shadow memory and is queued when a
//           read is issued, then popped when the model signals Ready.
// -----------------------------------------------------------------------------
module tb_sram_wait_model;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_wait_model_if #(.DATA_W(16), .ADDR_W(20), .CNT_W(16)) bus_a ();
    sram_wait_model_if #(.DATA_W(32), .ADDR_W(20), .CNT_W(4))  bus_b ();

    wire  [15:0] io_a;
    logic [15:0] tb_io_a = '0;
    logic        tb_oe_a = 1'b0;
    assign io_a = tb_oe_a ? tb_io_a : 'z;

    wire  [31:0] io_b;
    logic [31:0] tb_io_b = '0;
    logic        tb_oe_b = 1'b0;
    assign io_b = tb_oe_b ? tb_io_b : 'z;

    sram_wait_model #(
        .DATA_W(16), .ADDR_W(20), .DEPTH(256), .READ_LAT(2), .CNT_W(16)
    ) dut_a (
        .Clk(clk), .Reset(rst), .bus(bus_a), .I_O(io_a)
    );

    sram_wait_model #(
        .DATA_W(32), .ADDR_W(20), .DEPTH(256), .READ_LAT(0), .CNT_W(4)
    ) dut_b (
        .Clk(clk), .Reset(rst), .bus(bus_b), .I_O(io_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q [$];
    logic [15:0] model_mem [256];
    logic [15:0] exp_rd_a = '0;
    logic [15:0] exp_wr_a = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [19:0] a, input logic [1:0] be, input logic [15:0] d);
        logic oor;
        oor = (a >= 20'd256);
        bus_a.CE = 1'b0; bus_a.WE = 1'b0; bus_a.OE = 1'b1;
        bus_a.A  = a;    bus_a.BE = be;
        tb_io_a  = d;    tb_oe_a  = 1'b1;
        step();
        chk("wr_ready", 32'(bus_a.Ready), 32'd1);
        chk("wr_err", 32'(bus_a.Err), 32'(oor));
        chk("wr_nodrive", 32'(dut_a.drive), 32'd0);
        if (!oor) begin
            exp_wr_a++;
            if (!be[0]) model_mem[a[7:0]][7:0]  = d[7:0];
            if (!be[1]) model_mem[a[7:0]][15:8] = d[15:8];
        end
        bus_a.WE = 1'b1; bus_a.CE = 1'b1; tb_oe_a = 1'b0;
        step();
        chk("wr_err_pulse", 32'(bus_a.Err), 32'd0);
        chk("wr_ready_off", 32'(bus_a.Ready), 32'd0);
        chk("wr_count", 32'(bus_a.wr_count), 32'(exp_wr_a));
    endtask

    task automatic rd_a(input logic [19:0] a, input logic [1:0] be, input string tag);
        logic        oor;
        logic [15:0] e;
        int          n;
        oor = (a >= 20'd256);
        if (oor) begin
            e = '0;
        end else begin
            e = model_mem[a[7:0]];
            if (be[0]) e[7:0]  = '0;
            if (be[1]) e[15:8] = '0;
        end
        sb_q.push_back(32'(e));
        bus_a.CE = 1'b0; bus_a.OE = 1'b0; bus_a.WE = 1'b1;
        bus_a.A  = a;    bus_a.BE = be;
        step();
        chk({tag, "_err"}, 32'(bus_a.Err), 32'(oor));
        n = 0;
        while (!(dut_a.drive && bus_a.Ready) && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        if (sb_q.size() > 0) chk({tag, "_data"}, 32'(io_a), sb_q.pop_front());
        chk({tag, "_err_pulse"}, 32'(bus_a.Err), 32'd0);
        exp_rd_a++;
        chk({tag, "_rdcnt"}, 32'(bus_a.rd_count), 32'(exp_rd_a));
        step();
        chk({tag, "_hold"}, 32'(dut_a.drive), 32'd1);
        chk({tag, "_hold_cnt"}, 32'(bus_a.rd_count), 32'(exp_rd_a));
        bus_a.CE = 1'b1; bus_a.OE = 1'b1;
        step();
        chk({tag, "_release"}, 32'(dut_a.drive), 32'd0);
        chk({tag, "_ready_off"}, 32'(bus_a.Ready), 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] eb;

        foreach (model_mem[i]) model_mem[i] = '0;

        // Reset with garbage on every input.
        bus_a.CE = 1'b0; bus_a.OE = 1'b0; bus_a.WE = 1'b0;
        bus_a.A  = 20'hFFFFF; bus_a.BE = 2'b01;
        tb_io_a  = 16'hDEAD; tb_oe_a = 1'b1;
        bus_b.CE = 1'b0; bus_b.OE = 1'b0; bus_b.WE = 1'b0;
        bus_b.A  = 20'h00003; bus_b.BE = 4'b1010;
        tb_io_b  = 32'h12345678; tb_oe_b = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_drive", 32'(dut_a.drive), 32'd0);
        chk("rst_ready", 32'(bus_a.Ready), 32'd0);
        chk("rst_err", 32'(bus_a.Err), 32'd0);
        chk("rst_rdcnt", 32'(bus_a.rd_count), 32'd0);
        chk("rst_wrcnt", 32'(bus_a.wr_count), 32'd0);
        chk("rst_b_ready", 32'(bus_b.Ready), 32'd0);
        chk("rst_b_wrcnt", 32'(bus_b.wr_count), 32'd0);
        bus_a.CE = 1'b1; bus_a.OE = 1'b1; bus_a.WE = 1'b1; tb_oe_a = 1'b0;
        bus_b.CE = 1'b1; bus_b.OE = 1'b1; bus_b.WE = 1'b1; tb_oe_b = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Full-word write then read back with READ_LAT=2.
        wr_a(20'd5, 2'b00, 16'hBEEF);
        rd_a(20'd5, 2'b00, "beef");
        chk("beef_rdcnt1", 32'(bus_a.rd_count), 32'd1);
        chk("beef_wrcnt1", 32'(bus_a.wr_count), 32'd1);

        // Byte lanes.
        wr_a(20'd7, 2'b00, 16'h0000);
        wr_a(20'd7, 2'b10, 16'h1234);
        rd_a(20'd7, 2'b00, "lane_wr");
        rd_a(20'd5, 2'b01, "lane_rd");
        wr_a(20'd7, 2'b11, 16'hFFFF);
        rd_a(20'd7, 2'b00, "lane_none");

        // Read abort: A changes during RD_WAIT.
        bus_a.CE = 1'b0; bus_a.OE = 1'b0; bus_a.WE = 1'b1;
        bus_a.A  = 20'd5; bus_a.BE = 2'b00;
        step();
        step();
        bus_a.A = 20'd6;
        step();
        step();
        chk("abort_nodrive", 32'(dut_a.drive), 32'd0);
        bus_a.CE = 1'b1; bus_a.OE = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("abort_nodrive2", 32'(dut_a.drive), 32'd0);
        chk("abort_rdcnt", 32'(bus_a.rd_count), 32'(exp_rd_a));

        // Reset while driving releases the bus at that edge; memory survives.
        sb_q.push_back(32'(model_mem[5]));
        bus_a.CE = 1'b0; bus_a.OE = 1'b0; bus_a.WE = 1'b1;
        bus_a.A  = 20'd5; bus_a.BE = 2'b00;
        step();
        n = 0;
        while (!(dut_a.drive && bus_a.Ready) && n < 40) begin
            step();
            n++;
        end
        chk("rstdrv_lat", 32'(n), 32'd3);
        if (sb_q.size() > 0) chk("rstdrv_data", 32'(io_a), sb_q.pop_front());
        rst = 1'b1;
        step();
        chk("rstdrv_release", 32'(dut_a.drive), 32'd0);
        chk("rstdrv_ready", 32'(bus_a.Ready), 32'd0);
        chk("rstdrv_rdcnt", 32'(bus_a.rd_count), 32'd0);
        chk("rstdrv_wrcnt", 32'(bus_a.wr_count), 32'd0);
        rst = 1'b0;
        bus_a.CE = 1'b1; bus_a.OE = 1'b1;
        exp_rd_a = '0;
        exp_wr_a = '0;
        step();
        rd_a(20'd5, 2'b00, "post_rst");

        // Out of range: write dropped (index 44 aliases 300), read returns 0.
        wr_a(20'd44, 2'b00, 16'hA5C3);
        wr_a(20'd300, 2'b00, 16'hFFFF);
        rd_a(20'd44, 2'b00, "oor_alias");
        rd_a(20'd300, 2'b00, "oor_rd");

        // WE and OE both low: treated as a write, bus never driven.
        bus_a.CE = 1'b0; bus_a.WE = 1'b0; bus_a.OE = 1'b0;
        bus_a.A  = 20'd9; bus_a.BE = 2'b00;
        tb_io_a  = 16'h5A5A; tb_oe_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("weoe_nodrive", 32'(dut_a.drive), 32'd0);
            chk("weoe_ready", 32'(bus_a.Ready), 32'd1);
        end
        model_mem[9] = 16'h5A5A;
        exp_wr_a++;
        bus_a.CE = 1'b1; bus_a.WE = 1'b1; bus_a.OE = 1'b1; tb_oe_a = 1'b0;
        step();
        chk("weoe_wrcnt", 32'(bus_a.wr_count), 32'(exp_wr_a));
        rd_a(20'd9, 2'b00, "weoe_rd");

        // Instance B: 32-bit, zero wait states, 4-bit counters.
        bus_b.CE = 1'b0; bus_b.WE = 1'b0; bus_b.OE = 1'b1;
        bus_b.A  = 20'd3; bus_b.BE = 4'b0000;
        tb_io_b  = 32'hCAFEF00D; tb_oe_b = 1'b1;
        step();
        chk("b_wr_ready", 32'(bus_b.Ready), 32'd1);
        bus_b.CE = 1'b1; bus_b.WE = 1'b1; tb_oe_b = 1'b0;
        step();
        chk("b_wrcnt", 32'(bus_b.wr_count), 32'd1);
        for (int r = 0; r < 17; r++) begin
            bus_b.BE = (r == 5) ? 4'b0101 : 4'b0000;
            eb = (r == 5) ? 32'hCA00F000 : 32'hCAFEF00D;
            sb_q.push_back(eb);
            bus_b.CE = 1'b0; bus_b.OE = 1'b0; bus_b.WE = 1'b1; bus_b.A = 20'd3;
            step();
            n = 0;
            while (!(dut_b.drive && bus_b.Ready) && n < 40) begin
                step();
                n++;
            end
            chk("b_lat", 32'(n), 32'd1);
            if (sb_q.size() > 0) chk("b_data", io_b, sb_q.pop_front());
            bus_b.CE = 1'b1; bus_b.OE = 1'b1;
            step();
        end
        chk("b_rdcnt_wrap", 32'(bus_b.rd_count), 32'd1);
        chk("b_err", 32'(bus_b.Err), 32'd0);
        chk("b_release", 32'(dut_b.drive), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
